// File: rtl/bcd_xs3_seq_ctrl.sv
// Sequencer that converts a packed BCD word to excess-3 one digit at a time
// by driving an external serial BCD-to-XS3 converter (clear, shift in, calc, shift out).
module bcd_xs3_seq_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [4*DIGITS-1:0]   xs3_out,
    output logic                  cv_rst,
    output logic                  cv_in,
    input  logic                  cv_out,
    output logic [2:0]            dbg_state
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CLR,
        S_SHIFT,
        S_CALC,
        S_COLLECT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [4*DIGITS-1:0]   r_work;
    logic [4*DIGITS-1:0]   r_shadow;
    logic [4*DIGITS-1:0]   r_xs3;
    logic [3:0]            r_hold;
    logic [IW-1:0]         r_idx;
    logic [1:0]            r_bit;
    logic                  r_err;

    logic                  w_bad;
    logic [3:0]            w_digit;
    logic [4*DIGITS-1:0]   w_shadow_upd;

    // Any latched digit above 9 rejects the whole word before the converter is touched.
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_work[4*i +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    always_comb begin
        w_digit      = 4'd0;
        w_shadow_upd = r_shadow;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_digit               = r_work[4*i +: 4];
                w_shadow_upd[4*i +: 4] = r_hold;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_CHECK;
            S_CHECK:   w_state_nxt = w_bad ? S_DONE : S_CLR;
            S_CLR:     w_state_nxt = S_SHIFT;
            S_SHIFT:   if (r_bit == 2'd3) w_state_nxt = S_CALC;
            S_CALC:    w_state_nxt = S_COLLECT;
            S_COLLECT: if (r_bit == 2'd3) w_state_nxt = S_NEXT;
            S_NEXT:    w_state_nxt = (r_idx == '0) ? S_DONE : S_CLR;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work   <= '0;
            r_shadow <= '0;
            r_xs3    <= '0;
            r_hold   <= 4'd0;
            r_idx    <= '0;
            r_bit    <= 2'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work <= bcd_in;
                        r_err  <= 1'b0;
                        r_idx  <= IW'(DIGITS - 1);
                        r_bit  <= 2'd0;
                    end
                end
                S_CHECK: begin
                    if (w_bad) r_err <= 1'b1;
                end
                S_CLR: begin
                    r_bit  <= 2'd0;
                    r_hold <= 4'd0;
                end
                S_SHIFT: r_bit <= r_bit + 2'd1;
                S_CALC:  r_bit <= 2'd0;
                S_COLLECT: begin
                    r_hold <= {r_hold[2:0], cv_out};
                    r_bit  <= r_bit + 2'd1;
                end
                // The last digit's write and the output load share one edge so
                // xs3_out is already valid in the DONE cycle.
                S_NEXT: begin
                    r_shadow <= w_shadow_upd;
                    if (r_idx == '0) begin
                        r_xs3 <= w_shadow_upd;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cv_in = 1'b0;
        if (r_state == S_SHIFT) begin
            cv_in = w_digit[~r_bit];
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;
    assign xs3_out   = r_xs3;
    assign cv_rst    = rst | (r_state == S_CLR);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Bench for bcd_xs3_seq_ctrl: behavioural serial converter, cycle-accurate
// handshake checks and a result scoreboard, plus a single-digit instance.
module tb_bcd_xs3_seq_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [15:0] bcd_in;
    logic        busy, done, err, cv_rst, cv_in, cv_out;
    logic [15:0] xs3_out;
    logic [2:0]  dbg_state;

    logic        start1;
    logic [3:0]  bcd1;
    logic        busy1, done1, err1, cv_rst1, cv_in1, cv_out1;
    logic [3:0]  xs31;
    logic [2:0]  dbg_state1;

    bcd_xs3_seq_ctrl #(.DIGITS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .err(err), .xs3_out(xs3_out),
        .cv_rst(cv_rst), .cv_in(cv_in), .cv_out(cv_out), .dbg_state(dbg_state)
    );

    bcd_xs3_seq_ctrl #(.DIGITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .bcd_in(bcd1),
        .busy(busy1), .done(done1), .err(err1), .xs3_out(xs31),
        .cv_rst(cv_rst1), .cv_in(cv_in1), .cv_out(cv_out1), .dbg_state(dbg_state1)
    );

    // Serial converter model: 4 bits in after reset, one calc cycle, 4 bits out MSB first.
    logic [3:0] m_cnt, m_sh, m_out;
    always @(posedge clk) begin
        if (cv_rst) begin
            m_cnt <= 4'd0; m_sh <= 4'd0; m_out <= 4'd0;
        end else begin
            if (m_cnt < 4'd4) m_sh <= {m_sh[2:0], cv_in};
            if (m_cnt == 4'd4) m_out <= m_sh + 4'd3;
            if (m_cnt != 4'd15) m_cnt <= m_cnt + 4'd1;
        end
    end
    always_comb begin
        cv_out = 1'b0;
        case (m_cnt)
            4'd5: cv_out = m_out[3];
            4'd6: cv_out = m_out[2];
            4'd7: cv_out = m_out[1];
            4'd8: cv_out = m_out[0];
            default: ;
        endcase
    end

    logic [3:0] m1_cnt, m1_sh, m1_out;
    always @(posedge clk) begin
        if (cv_rst1) begin
            m1_cnt <= 4'd0; m1_sh <= 4'd0; m1_out <= 4'd0;
        end else begin
            if (m1_cnt < 4'd4) m1_sh <= {m1_sh[2:0], cv_in1};
            if (m1_cnt == 4'd4) m1_out <= m1_sh + 4'd3;
            if (m1_cnt != 4'd15) m1_cnt <= m1_cnt + 4'd1;
        end
    end
    always_comb begin
        cv_out1 = 1'b0;
        case (m1_cnt)
            4'd5: cv_out1 = m1_out[3];
            4'd6: cv_out1 = m1_out[2];
            4'd7: cv_out1 = m1_out[1];
            4'd8: cv_out1 = m1_out[0];
            default: ;
        endcase
    end

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    logic [15:0] last_good;

    int          d_cnt, d_cyc;
    logic [15:0] d_xs3;
    logic        d_err;
    logic [63:0] tr_cvin, tr_cvrst, tr_busy;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a word with start for one IDLE cycle; returns in cycle 1 after the accepting edge.
    task automatic accept(input logic [15:0] w);
        bcd_in = w;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Observes cycles 1..maxc of a run, driving start per mask and bcd_in with junk.
    task automatic watch(input int maxc, input logic [63:0] smask, input logic [15:0] bcd_during);
        d_cnt = 0; d_cyc = -1; d_xs3 = 16'h0; d_err = 1'b0;
        tr_cvin = '0; tr_cvrst = '0; tr_busy = '0;
        for (int c = 1; c <= maxc; c++) begin
            start  = smask[c];
            bcd_in = bcd_during;
            tr_cvin[c]  = cv_in;
            tr_cvrst[c] = cv_rst;
            tr_busy[c]  = busy;
            if (done === 1'b1) begin
                d_cnt++; d_cyc = c; d_xs3 = xs3_out; d_err = err;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic pop_exp();
        if (exp_q.size() == 0) exp_v = 16'hxxxx;
        else exp_v = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0; bcd_in = 16'h0; bcd1 = 4'h0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (xs3_out !== 16'h0) begin errors++; $display("FAIL reset_xs3 got=%h exp=0000", xs3_out); end
        checks++; if (cv_in !== 1'b0) begin errors++; $display("FAIL reset_cv_in got=%b exp=0", cv_in); end
        checks++; if (cv_rst !== 1'b1) begin errors++; $display("FAIL reset_cv_rst got=%b exp=1", cv_rst); end
        checks++; if (xs31 !== 4'h0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_dut1 got xs3=%h busy=%b exp 0/0", xs31, busy1); end
        rst = 1'b0;
        tick();
        last_good = 16'h0;
    endtask

    task automatic test_basic_1234();
        logic [63:0] exp_rst_tr;
        exp_q.push_back(16'h4567);
        accept(16'h1234);
        watch(48, 64'h0, 16'($urandom));
        pop_exp();
        exp_rst_tr = '0;
        exp_rst_tr[2] = 1'b1; exp_rst_tr[13] = 1'b1; exp_rst_tr[24] = 1'b1; exp_rst_tr[35] = 1'b1;
        checks++; if ({tr_cvin[3], tr_cvin[4], tr_cvin[5], tr_cvin[6]} !== 4'b0001) begin errors++; $display("FAIL basic_cv_in_d3 got=%b exp=0001", {tr_cvin[3], tr_cvin[4], tr_cvin[5], tr_cvin[6]}); end
        checks++; if ({tr_cvin[14], tr_cvin[15], tr_cvin[16], tr_cvin[17]} !== 4'b0010) begin errors++; $display("FAIL basic_cv_in_d2 got=%b exp=0010", {tr_cvin[14], tr_cvin[15], tr_cvin[16], tr_cvin[17]}); end
        checks++; if (tr_cvrst !== exp_rst_tr) begin errors++; $display("FAIL basic_cv_rst_trace got=%h exp=%h", tr_cvrst, exp_rst_tr); end
        checks++; if (d_cnt !== 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", d_cnt); end
        checks++; if (d_cyc !== 46) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=46", d_cyc); end
        checks++; if (d_xs3 !== exp_v) begin errors++; $display("FAIL basic_xs3 got=%h exp=%h", d_xs3, exp_v); end
        checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", d_err); end
        checks++; if (tr_busy[46] !== 1'b1 || tr_busy[47] !== 1'b0) begin errors++; $display("FAIL basic_busy_edge got=%b%b exp=10", tr_busy[46], tr_busy[47]); end
        last_good = 16'h4567;
    endtask

    task automatic test_invalid_digit();
        exp_q.push_back(last_good);
        accept(16'h12A4);
        watch(6, 64'h0, 16'($urandom));
        pop_exp();
        checks++; if (d_cnt !== 1 || d_cyc !== 2) begin errors++; $display("FAIL invalid_done got cnt=%0d cyc=%0d exp 1/2", d_cnt, d_cyc); end
        checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL invalid_err got=%b exp=1", d_err); end
        checks++; if (d_xs3 !== exp_v) begin errors++; $display("FAIL invalid_xs3 got=%h exp=%h", d_xs3, exp_v); end
        checks++; if (tr_cvrst !== 64'h0) begin errors++; $display("FAIL invalid_cv_rst got=%h exp=0", tr_cvrst); end
        checks++; if (tr_cvin !== 64'h0) begin errors++; $display("FAIL invalid_cv_in got=%h exp=0", tr_cvin); end
        checks++; if (tr_busy[3] !== 1'b0) begin errors++; $display("FAIL invalid_busy3 got=%b exp=0", tr_busy[3]); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL invalid_err_hold got=%b exp=1", err); end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(16'hCCCC);
        accept(16'h9999);
        // start stays high; the following word is already on bcd_in for the cycle-47 accept.
        watch(47, 64'h0000_FFFF_FFFF_FFFE, 16'h0000);
        pop_exp();
        checks++; if (d_cnt !== 1 || d_cyc !== 46) begin errors++; $display("FAIL b2b_first_done got cnt=%0d cyc=%0d exp 1/46", d_cnt, d_cyc); end
        checks++; if (d_xs3 !== exp_v || d_err !== 1'b0) begin errors++; $display("FAIL b2b_first_xs3 got=%h err=%b exp=%h err=0", d_xs3, d_err, exp_v); end
        exp_q.push_back(16'h3333);
        watch(48, 64'h0000_7FFF_FFFF_FFFE, 16'($urandom));
        pop_exp();
        checks++; if (d_cnt !== 1 || d_cyc !== 46) begin errors++; $display("FAIL b2b_second_done got cnt=%0d cyc=%0d exp 1/46", d_cnt, d_cyc); end
        checks++; if (d_xs3 !== exp_v) begin errors++; $display("FAIL b2b_second_xs3 got=%h exp=%h", d_xs3, exp_v); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after got=%b exp=0", busy); end
        last_good = 16'h3333;
    endtask

    task automatic test_start_ignored();
        exp_q.push_back(16'h89AB);
        accept(16'h5678);
        watch(50, 64'h0000_0000_0010_0020, 16'($urandom));
        pop_exp();
        checks++; if (d_cnt !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", d_cnt); end
        checks++; if (d_cyc !== 46) begin errors++; $display("FAIL ignore_done_cycle got=%0d exp=46", d_cyc); end
        checks++; if (d_xs3 !== exp_v) begin errors++; $display("FAIL ignore_xs3 got=%h exp=%h", d_xs3, exp_v); end
        checks++; if (tr_busy[47] !== 1'b0) begin errors++; $display("FAIL ignore_busy47 got=%b exp=0", tr_busy[47]); end
        last_good = 16'h89AB;
    endtask

    task automatic test_reset_abort();
        int n_done;
        accept(16'h4321);
        repeat (14) tick();
        rst = 1'b1;
        #1;
        checks++; if (cv_rst !== 1'b1) begin errors++; $display("FAIL abort_cv_rst_c15 got=%b exp=1", cv_rst); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (xs3_out !== 16'h0) begin errors++; $display("FAIL abort_xs3 got=%h exp=0000", xs3_out); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL abort_done_err got=%b%b exp=00", done, err); end
        checks++; if (cv_rst !== 1'b1) begin errors++; $display("FAIL abort_cv_rst_c16 got=%b exp=1", cv_rst); end
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done === 1'b1 || busy !== 1'b0) n_done++;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
        last_good = 16'h0;
        exp_q.push_back(16'h3334);
        accept(16'h0001);
        watch(48, 64'h0, 16'($urandom));
        pop_exp();
        checks++; if (d_cnt !== 1 || d_cyc !== 46) begin errors++; $display("FAIL after_abort_done got cnt=%0d cyc=%0d exp 1/46", d_cnt, d_cyc); end
        checks++; if (d_xs3 !== exp_v) begin errors++; $display("FAIL after_abort_xs3 got=%h exp=%h", d_xs3, exp_v); end
    endtask

    task automatic test_single_digit();
        int cyc1, cnt1;
        logic [3:0] x1;
        cyc1 = -1; cnt1 = 0; x1 = 4'h0;
        exp_q.push_back(16'h000A);
        bcd1 = 4'h7; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            bcd1 = 4'($urandom_range(0, 15));
            if (done1 === 1'b1) begin cnt1++; cyc1 = c; x1 = xs31; end
            tick();
        end
        pop_exp();
        checks++; if (cnt1 !== 1 || cyc1 !== 13) begin errors++; $display("FAIL d1_done got cnt=%0d cyc=%0d exp 1/13", cnt1, cyc1); end
        checks++; if ({12'h0, x1} !== exp_v) begin errors++; $display("FAIL d1_xs3 got=%h exp=%h", x1, exp_v[3:0]); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0; bcd_in = 16'h0; bcd1 = 4'h0;
        test_reset();
        test_basic_1234();
        test_invalid_digit();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
        test_single_digit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_xs3_seq_ctrl.md
# bcd_xs3_seq_ctrl

Sequencer for the serial BCD-to-excess-3 converter FSM. It accepts a multi-digit packed BCD word through a start/busy/done handshake and validates every digit. It then runs the shared serial converter once per digit: clear it, shift in 4 bits, wait one compute cycle, shift out 4 bits. The converted digits are assembled into a packed XS3 word. It sits between a parallel host and one instance of the serial converter, which it owns exclusively.

## Interface
- DIGITS, 4: number of BCD digits per word (1..8).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- bcd_in  in  4*DIGITS  packed BCD word. Digit i is bcd_in[4i+3:4i]. Latched on the accepting edge.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  high if the last accepted word held a digit >9. Held until the next accept.
- xs3_out  out  4*DIGITS  last successful result. Digit i corresponds to bcd digit i.
- cv_rst  out  1  converter reset, equal to rst OR (state==CLR).
- cv_in  out  1  converter serial input. 0 outside SHIFT.
- cv_out  in  1  converter serial output.

## Operation
- States: IDLE, CHECK, CLR, SHIFT, CALC, COLLECT, NEXT, DONE.
- IDLE:
  - On start=1, latch bcd_in into the work register, clear err, set digit index to DIGITS-1 (most significant digit first).
  - Go to CHECK.
- CHECK:
  - If any latched digit >9: set err=1 and go to DONE. No converter activity; xs3_out unchanged.
  - Otherwise go to CLR.
- CLR: cv_rst=1 for 1 cycle, then SHIFT.
- SHIFT: 4 cycles. cv_in carries the current digit MSB first (bit3, bit2, bit1, bit0). Bit counter 0..3.
- CALC: 1 cycle with cv_in=0.
- COLLECT:
  - 4 cycles. cv_out is sampled at the end of each cycle.
  - Sampled bits are shifted MSB first into a 4-bit holding register.
- NEXT:
  - Write the holding register into the result shadow at the current index.
  - If index==0, go to DONE. Otherwise decrement the index and go to CLR.
- DONE:
  - done=1 for 1 cycle. On a successful run, xs3_out is loaded from the shadow on entry.
  - Return to IDLE.
- Converter contract: after a 1-cycle cv_rst, 4 input bits, and 1 calc cycle, the converter presents its 4 XS3 bits MSB first on cv_out in the next 4 cycles.
- start while busy is ignored, and no request is queued. Changes to bcd_in after accept are ignored.
- Digits are 4-bit and never carry between digits. Each XS3 digit equals the BCD digit + 3.

## Timing
- Reset values: busy=0, done=0, err=0, xs3_out=0, cv_in=0, cv_rst=1 while rst=1. Work, shadow and counters are cleared; state is IDLE.
- Accepting edge E0, cycles numbered after it:
  - Cycle 1: CHECK.
  - Per digit: 11 cycles (CLR 1, SHIFT 4, CALC 1, COLLECT 4, NEXT 1).
  - For digit k (0 = first processed), CLR falls in cycle 2+11k.
- Valid run: DONE in cycle 2+11*DIGITS. For DIGITS=4 that is cycle 46, which has done=1 and the new xs3_out. busy is low from cycle 47. start is accepted again at the end of cycle 47.
- Invalid run: DONE in cycle 2 with err=1. busy is low from cycle 3.
- rst mid-operation: abort at that edge.
  - All outputs return to reset values, including xs3_out=0.
  - No done pulse. The converter is held in reset.

## Test plan
- 0x1234 start (DIGITS=4):
  - cv_in shows 0,0,0,1 in cycles 3-6.
  - done only in cycle 46; xs3_out=0x4567, err=0.
- 0x9999 -> xs3_out=0xCCCC; 0x0000 -> 0x3333. Run back-to-back with start held high: the second accept lands in IDLE, cycle 47.
- 0x12A4 after a prior 0x1234 result:
  - err=1, done in cycle 2, xs3_out stays 0x4567.
  - cv_rst never pulses; cv_in stays 0.
- start pulses at cycles 5 and 20 during a 0x5678 run:
  - Both ignored. Single done in cycle 46, xs3_out=0x89AB.
- rst asserted at cycle 15 of a 0x4321 run:
  - busy=0 and xs3_out=0 next cycle, no done pulse, cv_rst=1 during reset.
  - A subsequent 0x0001 run gives 0x3334.
- DIGITS=1, bcd 0x7: done in cycle 13, xs3_out=0xA.
